rr_stream_mux: RTL

- Parametrised N-input, WIDTH-bit stream multiplexer with per-channel valid/ready handshakes and one registered output stage.
- Selection is by round-robin arbitration, fixed priority, or an externally forced select, chosen at run time.
- Next-generation replacement for the combinational 4x1 mux on datapaths that need backpressure and fair sharing of one downstream consumer.

---
 rtl/rr_stream_mux.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N_IN-channel WIDTH-bit stream multiplexer with valid/ready
// handshakes and a single registered output stage. The grant is chosen by
// round-robin, fixed priority or a forced select, picked at run time by mode.
// Optional packet lock (in_last/out_last) is built when the macro
// RR_STREAM_MUX_LAST_EN is defined.
module rr_stream_mux #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
`ifdef RR_STREAM_MUX_LAST_EN
    input  logic [N_IN-1:0]       in_last,
    output logic                  out_last,
`endif
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      force_sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_sel
);

    typedef enum logic [1:0] {
        MODE_RR     = 2'b00,
        MODE_FIXED  = 2'b01,
        MODE_FORCED = 2'b10,
        MODE_RR_ALT = 2'b11
    } mode_e;

    mode_e            mode_w;
    logic [WIDTH-1:0] ch_data [N_IN];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;
`ifdef RR_STREAM_MUX_LAST_EN
    logic             out_last_q,  out_last_d;
    logic             lock_q,      lock_d;
    logic [SEL_W-1:0] lock_sel_q,  lock_sel_d;
`endif

    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr_inc;

    assign mode_w  = mode_e'(mode);
    // The output register can take a new beat when empty or being drained.
    assign load_en = !out_valid_q || out_ready;
    assign ptr_inc = (grant_idx == SEL_W'(N_IN - 1)) ? '0 : grant_idx + 1'b1;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // Grant decision: pick one requesting channel according to mode and lock.
    always_comb begin
        int               wrap;
        logic [SEL_W-1:0] idx;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_idx = '0;
        wrap      = 0;
        idx       = '0;
        case (mode_w)
            MODE_FIXED: begin
                // Scan downward so the lowest valid index is the last one written.
                for (int i = N_IN - 1; i >= 0; i--) begin
                    if (in_valid[SEL_W'(i)]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
            MODE_FORCED: begin
                if ((int'(force_sel) < N_IN) && in_valid[force_sel]) begin
                    grant_vld = 1'b1;
                    grant_idx = force_sel;
                end
            end
            default: begin
                // Offsets scanned from far to near so the nearest to ptr wins.
                for (int k = N_IN - 1; k >= 0; k--) begin
                    wrap = int'(ptr_q) + k;
                    if (wrap >= N_IN) wrap = wrap - N_IN;
                    idx = SEL_W'(wrap);
                    if (in_valid[idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = idx;
                    end
                end
            end
        endcase
`ifdef RR_STREAM_MUX_LAST_EN
        // Mid-packet, only the owning channel may continue.
        if (lock_q) begin
            grant_vld = in_valid[lock_sel_q];
            grant_idx = lock_sel_q;
        end
`endif
    end

    // Accept strobe: one-hot on the granted channel when a load happens.
    always_comb begin
        in_ready = '0;
        if (reset && load_en && grant_vld) in_ready[grant_idx] = 1'b1;
    end

    // Next-state of the output stage, round-robin pointer and packet lock.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef RR_STREAM_MUX_LAST_EN
        out_last_d  = out_last_q;
        lock_d      = lock_q;
        lock_sel_d  = lock_sel_q;
`endif
        if (load_en) begin
            // With no grant the register empties; data and sel keep their last value.
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = ch_data[grant_idx];
                out_sel_d  = grant_idx;
`ifdef RR_STREAM_MUX_LAST_EN
                out_last_d = in_last[grant_idx];
                lock_d     = !in_last[grant_idx];
                lock_sel_d = grant_idx;
                if (in_last[grant_idx]) ptr_d = ptr_inc;
`else
                ptr_d      = ptr_inc;
`endif
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef RR_STREAM_MUX_LAST_EN
            out_last_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_sel_q  <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef RR_STREAM_MUX_LAST_EN
            out_last_q  <= out_last_d;
            lock_q      <= lock_d;
            lock_sel_q  <= lock_sel_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
`ifdef RR_STREAM_MUX_LAST_EN
    assign out_last  = out_last_q;
`endif

endmodule
